// File: rtl/bus_read_buffer_pkg.sv
// Shared PE-to-PE bus definitions used by the arbiter, the PE bus interface
// and the per-PE receive buffer.
package bus_read_buffer_pkg;

    localparam int BUS_NUM_PE     = 8;
    localparam int BUS_DATA_W     = 16;
    localparam int BUS_ADDR_W     = 3;
    localparam int BUS_FIFO_DEPTH = 8;
    // Arbiter decision + strobe + capture cycles still in flight when full rises.
    localparam int BUS_SKID       = 3;

    typedef logic [BUS_ADDR_W-1:0] pe_idx_t;
    typedef logic [BUS_DATA_W-1:0] bus_data_t;

    function automatic int fifo_count_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/bus_read_buffer_rx_fifo.sv
// Single-source receive FIFO: registered almost-full / not-empty flags,
// combinational head word, and an overflow pulse for a push into a full FIFO.
module bus_rx_fifo
    import bus_read_buffer_pkg::*;
#(
    parameter int DATA_LEN = BUS_DATA_W,
    parameter int DEPTH    = BUS_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [DATA_LEN-1:0]    push_data,
    input  logic                   pop,
    input  logic [$clog2(DEPTH):0] af_thresh,
    output logic                   almost_full,
    output logic                   not_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic [DATA_LEN-1:0]    head_data,
    output logic                   overflow
);

    localparam int CW = fifo_count_w(DEPTH);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                almost_full_q, almost_full_d;
    logic                not_empty_q, not_empty_d;
    logic [DATA_LEN-1:0] mem_q [DEPTH];
    logic                full, do_push, do_pop;

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    always_comb begin
        full          = (count_q == CW'(DEPTH));
        do_pop        = pop && (count_q != '0);
        do_push       = push && (!full || do_pop);
        overflow      = push && full && !do_pop;
        wr_ptr_d      = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d      = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d       = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end
        almost_full_d = (count_d >= af_thresh);
        not_empty_d   = (count_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            almost_full_q <= 1'b0;
            not_empty_q   <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            almost_full_q <= almost_full_d;
            not_empty_q   <= not_empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign almost_full = almost_full_q;
    assign not_empty   = not_empty_q;
    assign count       = count_q;
    assign head_data   = mem_q[rd_ptr_q];

endmodule

// File: rtl/bus_read_buffer.sv
// Per-PE receive endpoint: captures bus words one cycle after the arbiter
// strobe, sorts them into per-source FIFOs and serves pop-by-source reads.
module bus_read_buffer
    import bus_read_buffer_pkg::*;
#(
    parameter int NUM_PE       = BUS_NUM_PE,
    parameter int DATA_LEN     = BUS_DATA_W,
    parameter int BUS_ADDR_LEN = BUS_ADDR_W,
    parameter int DEPTH        = BUS_FIFO_DEPTH,
    parameter int SKID         = BUS_SKID
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rd_from_bus,
    input  logic [DATA_LEN-1:0]     data_bus,
    input  logic [BUS_ADDR_LEN-1:0] addr_bus,
    output logic [NUM_PE-1:0]       rd_buffer_full,
    output logic [NUM_PE-1:0]       src_not_empty,
    input  logic                    pop_req,
    input  logic [BUS_ADDR_LEN-1:0] pop_src,
    output logic                    pop_valid,
    output logic [DATA_LEN-1:0]     pop_data,
    output logic                    overflow_err
);

    localparam int                    CW        = fifo_count_w(DEPTH);
    localparam logic [CW-1:0]         AF_THRESH = CW'(DEPTH - SKID);
    localparam logic [BUS_ADDR_LEN:0] NUM_PE_W  = (BUS_ADDR_LEN + 1)'(NUM_PE);

    logic                capture_pending_q, capture_pending_d;
    logic                init_q, init_d;
    logic                pop_valid_q, pop_valid_d;
    logic [DATA_LEN-1:0] pop_data_q, pop_data_d;
    logic                overflow_err_q, overflow_err_d;

    logic [NUM_PE-1:0]   push_vec, pop_vec, fifo_ovf;
    logic [DATA_LEN-1:0] head [NUM_PE];
    logic [CW-1:0]       cnt [NUM_PE];
    logic                addr_ok, pop_hit;
    logic [DATA_LEN-1:0] pop_head;

    // init_q masks a strobe that coincides with the first edge after reset release.
    always_comb begin
        init_d            = 1'b0;
        capture_pending_d = rd_from_bus && !init_q;
        addr_ok           = ({1'b0, addr_bus} < NUM_PE_W);
        push_vec          = '0;
        pop_vec           = '0;
        pop_hit           = 1'b0;
        pop_head          = '0;
        for (int s = 0; s < NUM_PE; s++) begin
            push_vec[s] = capture_pending_q && (addr_bus == BUS_ADDR_LEN'(s));
            pop_vec[s]  = pop_req && (pop_src == BUS_ADDR_LEN'(s));
            if (pop_vec[s] && (cnt[s] != '0)) begin
                pop_hit  = 1'b1;
                pop_head = head[s];
            end
        end
        pop_valid_d    = pop_hit;
        pop_data_d     = pop_hit ? pop_head : pop_data_q;
        overflow_err_d = overflow_err_q | (capture_pending_q && !addr_ok) | (|fifo_ovf);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            capture_pending_q <= 1'b0;
            init_q            <= 1'b1;
            pop_valid_q       <= 1'b0;
            pop_data_q        <= '0;
            overflow_err_q    <= 1'b0;
        end else begin
            capture_pending_q <= capture_pending_d;
            init_q            <= init_d;
            pop_valid_q       <= pop_valid_d;
            pop_data_q        <= pop_data_d;
            overflow_err_q    <= overflow_err_d;
        end
    end

    for (genvar s = 0; s < NUM_PE; s++) begin : g_src
        bus_rx_fifo #(
            .DATA_LEN (DATA_LEN),
            .DEPTH    (DEPTH)
        ) u_fifo (
            .clk         (clk),
            .rst         (rst),
            .push        (push_vec[s]),
            .push_data   (data_bus),
            .pop         (pop_vec[s]),
            .af_thresh   (AF_THRESH),
            .almost_full (rd_buffer_full[s]),
            .not_empty   (src_not_empty[s]),
            .count       (cnt[s]),
            .head_data   (head[s]),
            .overflow    (fifo_ovf[s])
        );
    end

    assign pop_valid    = pop_valid_q;
    assign pop_data     = pop_data_q;
    assign overflow_err = overflow_err_q;

endmodule

// File: tb/tb_bus_read_buffer.sv
// Scoreboard bench for bus_read_buffer: an 8-source instance for the main
// checks plus a 6-source instance sharing the same stimulus for index checks.
module tb_bus_read_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_from_bus;
    logic [15:0] data_bus;
    logic [2:0]  addr_bus;
    logic        pop_req;
    logic [2:0]  pop_src;

    logic [7:0]  rbf8, sne8;
    logic        pv8, ovf8;
    logic [15:0] pd8;
    logic [5:0]  rbf6, sne6;
    logic        pv6, ovf6;
    logic [15:0] pd6;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] sb [$];
    logic [15:0] last_pd;
    logic [15:0] mon_exp;
    logic [2:0]  cap_a [$];
    logic [15:0] cap_d [$];

    always #5 clk = ~clk;

    bus_read_buffer #(.NUM_PE(8)) dut8 (
        .clk(clk), .rst(rst), .rd_from_bus(rd_from_bus), .data_bus(data_bus),
        .addr_bus(addr_bus), .rd_buffer_full(rbf8), .src_not_empty(sne8),
        .pop_req(pop_req), .pop_src(pop_src), .pop_valid(pv8), .pop_data(pd8),
        .overflow_err(ovf8)
    );

    bus_read_buffer #(.NUM_PE(6)) dut6 (
        .clk(clk), .rst(rst), .rd_from_bus(rd_from_bus), .data_bus(data_bus),
        .addr_bus(addr_bus), .rd_buffer_full(rbf6), .src_not_empty(sne6),
        .pop_req(pop_req), .pop_src(pop_src), .pop_valid(pv6), .pop_data(pd6),
        .overflow_err(ovf6)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every valid pop on the 8-source instance is matched to the scoreboard.
    always @(negedge clk) begin
        if (!rst && pv8) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got pop_valid=1 data 0x%0h expected no pop", pd8);
            end else begin
                mon_exp = sb.pop_front();
                chk("pop_data", {16'h0, pd8}, {16'h0, mon_exp});
            end
        end
    end

    task automatic cap(input logic [2:0] a, input logic [15:0] d);
        cap_a.push_back(a);
        cap_d.push_back(d);
    endtask

    // Issues the queued captures as back-to-back strobes; returns after the last write edge.
    task automatic run_caps();
        int n;
        n = cap_a.size();
        for (int k = 0; k <= n; k++) begin
            rd_from_bus = (k < n);
            if (k > 0) begin
                addr_bus = cap_a[k-1];
                data_bus = cap_d[k-1];
            end
            @(negedge clk);
        end
        rd_from_bus = 1'b0;
        cap_a.delete();
        cap_d.delete();
    endtask

    task automatic do_pop(input logic [2:0] src, input bit exp_valid, input logic [15:0] exp_d);
        pop_req = 1'b1;
        pop_src = src;
        if (exp_valid) begin
            sb.push_back(exp_d);
            last_pd = exp_d;
        end
        @(negedge clk);
        pop_req = 1'b0;
        if (!exp_valid) begin
            chk("empty_pop_valid", {31'h0, pv8}, 32'h0);
            chk("empty_pop_hold", {16'h0, pd8}, {16'h0, last_pd});
        end
    endtask

    initial begin
        rst         = 1'b1;
        rd_from_bus = 1'b0;
        data_bus    = '0;
        addr_bus    = '0;
        pop_req     = 1'b0;
        pop_src     = '0;
        last_pd     = '0;
        repeat (2) @(negedge clk);
        chk("rst_rbf", {24'h0, rbf8}, 32'h0);
        chk("rst_sne", {24'h0, sne8}, 32'h0);
        chk("rst_pv", {31'h0, pv8}, 32'h0);
        chk("rst_pd", {16'h0, pd8}, 32'h0);
        chk("rst_ovf", {31'h0, ovf8}, 32'h0);
        chk("rst6_rbf", {26'h0, rbf6}, 32'h0);
        chk("rst6_pd", {16'h0, pd6}, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Source 7 is real on the 8-PE instance but unused on the 6-PE one.
        chk("bad_idx_ovf_before", {31'h0, ovf6}, 32'h0);
        cap(3'd7, 16'h0777);
        run_caps();
        chk("bad_idx_ovf", {31'h0, ovf6}, 32'h1);
        chk("bad_idx_no_store", {26'h0, sne6}, 32'h0);
        chk("src7_stored", {24'h0, sne8}, 32'h80);
        chk("src7_no_ovf", {31'h0, ovf8}, 32'h0);
        do_pop(3'd7, 1'b1, 16'h0777);
        chk("unused_idx_pop", {31'h0, pv6}, 32'h0);
        chk("src7_drained", {24'h0, sne8}, 32'h0);

        do_pop(3'd4, 1'b0, 16'h0);

        cap(3'd3, 16'h1234);
        run_caps();
        chk("single_sne", {24'h0, sne8}, 32'h08);
        do_pop(3'd3, 1'b1, 16'h1234);
        chk("single_drained", {24'h0, sne8}, 32'h0);

        for (int i = 1; i <= 4; i++) cap(3'd5, 16'(i));
        run_caps();
        chk("af_count4", {24'h0, rbf8}, 32'h0);
        cap(3'd5, 16'd5);
        run_caps();
        chk("af_count5", {24'h0, rbf8}, 32'h20);
        for (int i = 6; i <= 8; i++) cap(3'd5, 16'(i));
        run_caps();
        chk("full_no_ovf", {31'h0, ovf8}, 32'h0);
        chk("full_rbf", {24'h0, rbf8}, 32'h20);
        chk("full_sne", {24'h0, sne8}, 32'h20);
        cap(3'd5, 16'd9);
        run_caps();
        chk("ovf_9th", {31'h0, ovf8}, 32'h1);
        for (int i = 1; i <= 8; i++) do_pop(3'd5, 1'b1, 16'(i));
        do_pop(3'd5, 1'b0, 16'h0);
        chk("drain_rbf", {24'h0, rbf8}, 32'h0);
        chk("drain_sne", {24'h0, sne8}, 32'h0);

        for (int i = 1; i <= 5; i++) cap(3'd5, 16'h0050 + 16'(i));
        run_caps();
        chk("pp_rbf_before", {24'h0, rbf8}, 32'h20);
        rd_from_bus = 1'b1;
        @(negedge clk);
        rd_from_bus = 1'b0;
        addr_bus    = 3'd5;
        data_bus    = 16'h0056;
        pop_req     = 1'b1;
        pop_src     = 3'd5;
        sb.push_back(16'h0051);
        last_pd     = 16'h0051;
        @(negedge clk);
        pop_req     = 1'b0;
        chk("pp_rbf_after", {24'h0, rbf8}, 32'h20);
        chk("pp_sne_after", {24'h0, sne8}, 32'h20);
        for (int i = 2; i <= 6; i++) do_pop(3'd5, 1'b1, 16'h0050 + 16'(i));
        do_pop(3'd5, 1'b0, 16'h0);
        chk("pp_drained", {24'h0, sne8}, 32'h0);

        cap(3'd1, 16'h00A1);
        cap(3'd6, 16'h0006);
        cap(3'd1, 16'h00A2);
        cap(3'd6, 16'h0007);
        run_caps();
        chk("il_sne", {24'h0, sne8}, 32'h42);
        do_pop(3'd6, 1'b1, 16'h0006);
        do_pop(3'd6, 1'b1, 16'h0007);
        do_pop(3'd1, 1'b1, 16'h00A1);
        do_pop(3'd1, 1'b1, 16'h00A2);
        chk("il_drained", {24'h0, sne8}, 32'h0);

        cap(3'd2, 16'h00B1);
        cap(3'd2, 16'h00B2);
        cap(3'd2, 16'h00B3);
        run_caps();
        chk("mid_rst_sne_before", {24'h0, sne8}, 32'h04);
        rst = 1'b1;
        #1;
        chk("mid_rst_rbf", {24'h0, rbf8}, 32'h0);
        chk("mid_rst_sne", {24'h0, sne8}, 32'h0);
        chk("mid_rst_pv", {31'h0, pv8}, 32'h0);
        chk("mid_rst_pd", {16'h0, pd8}, 32'h0);
        chk("mid_rst_ovf", {31'h0, ovf8}, 32'h0);
        last_pd = 16'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_sne", {24'h0, sne8}, 32'h0);
        do_pop(3'd2, 1'b0, 16'h0);

        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
